// File: rtl/ones_counter_seq_pkg.sv
// Shared types and helpers for the sequential ones counter.
package oc_pkg;

  typedef enum logic [1:0] {
    OC_IDLE  = 2'd0,
    OC_COUNT = 2'd1,
    OC_DONE  = 2'd2
  } oc_state_t;

  // Count cycles needed to walk a w-bit word c bits at a time.
  function automatic int oc_nbeats(int w, int c);
    return (w + c - 1) / c;
  endfunction

endpackage

// File: rtl/ones_counter_seq_popcount.sv
// Combinational ones count of a CHUNK-bit slice; CHUNK=3 is the classic one-counter cell.
module popcount_chunk #(
  parameter int unsigned CHUNK = 3
) (
  input  logic [CHUNK-1:0]         bits,
  output logic [$clog2(CHUNK+1)-1:0] ones_c
);

  localparam int unsigned PC_W = $clog2(CHUNK + 1);

  always_comb begin
    ones_c = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      ones_c = ones_c + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/ones_counter_seq.sv
// Sequential ones counter with per-frame running total; build with OC_SATURATE_EN
// to clamp the total at all-ones instead of wrapping.
module ones_counter_seq
  import oc_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned CHUNK = 3,
  parameter  int unsigned ACC_W = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [ACC_W-1:0] out_total,
  output logic             out_last,
  output logic             overflow
);

  localparam int unsigned NBEATS = oc_nbeats(WIDTH, CHUNK);
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned PC_W   = $clog2(CHUNK + 1);
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  oc_state_t          state, next_state;
  logic [WIDTH-1:0]   sr;
  logic [CNT_W-1:0]   cnt;
  logic [BEAT_W-1:0]  beat;
  logic               last_q;
  logic [ACC_W-1:0]   acc;

  logic [PC_W-1:0]    pc_c;
  logic [CNT_W-1:0]   cnt_next_c;
  logic [SUM_W-1:0]   sum_c;
  logic [ACC_W-1:0]   acc_next_c;

  popcount_chunk #(.CHUNK(CHUNK)) u_pc (
    .bits   (sr[CHUNK-1:0]),
    .ones_c (pc_c)
  );

  // Running count and frame total for the beat in progress.
  always_comb begin
    cnt_next_c = cnt + CNT_W'(pc_c);
    sum_c      = SUM_W'(acc) + SUM_W'(cnt_next_c);
`ifdef OC_SATURATE_EN
    acc_next_c = sum_c[ACC_W] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
    acc_next_c = sum_c[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OC_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      OC_IDLE:  if (in_valid && in_ready) next_state = OC_COUNT;
      OC_COUNT: if (beat == LAST_BEAT)    next_state = OC_DONE;
      OC_DONE:  if (out_ready)            next_state = OC_IDLE;
      default:                            next_state = OC_IDLE;
    endcase
  end

  // Datapath; in_ready is registered so it first rises one cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
      beat      <= '0;
      last_q    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_total <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      in_ready <= (next_state == OC_IDLE);
      case (state)
        OC_IDLE: begin
          if (in_valid && in_ready) begin
            sr     <= in_data;
            cnt    <= '0;
            beat   <= '0;
            last_q <= in_last;
          end
        end
        OC_COUNT: begin
          sr   <= sr >> CHUNK;
          cnt  <= cnt_next_c;
          beat <= beat + BEAT_W'(1);
          if (beat == LAST_BEAT) begin
            out_count <= cnt_next_c;
            out_total <= acc_next_c;
            acc       <= acc_next_c;
            overflow  <= overflow | sum_c[ACC_W];
            out_last  <= last_q;
            out_valid <= 1'b1;
          end
        end
        OC_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_q) begin
              acc      <= '0;
              overflow <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_counter_seq.sv
// Directed self-checking bench: default build, a narrow-accumulator build and a single-beat build.
module tb_ones_counter_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid, a_out_last, a_overflow;
  logic [3:0] a_out_count;
  logic [7:0] a_out_total;

  logic       b_in_ready, b_out_valid, b_out_last, b_overflow;
  logic [3:0] b_out_count;
  logic [3:0] b_out_total;

  logic       c_valid, c_last, c_out_ready;
  logic [2:0] c_data;
  logic       c_in_ready, c_out_valid, c_out_last, c_overflow;
  logic [1:0] c_out_count;
  logic [7:0] c_out_total;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ones_counter_seq #(.WIDTH(8), .CHUNK(3), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_count(a_out_count),
    .out_total(a_out_total), .out_last(a_out_last), .overflow(a_overflow));

  ones_counter_seq #(.WIDTH(8), .CHUNK(3), .ACC_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_count(b_out_count),
    .out_total(b_out_total), .out_last(b_out_last), .overflow(b_overflow));

  ones_counter_seq #(.WIDTH(3), .CHUNK(3), .ACC_W(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_in_ready), .in_data(c_data),
    .in_last(c_last), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_count(c_out_count),
    .out_total(c_out_total), .out_last(c_out_last), .overflow(c_overflow));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word to dut_a/dut_b and check that the result appears exactly 3 edges later.
  task automatic send_word(input logic [7:0] data, input logic last, input string tag);
    int waited = 0;
    while (!a_in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready"}, 32'(a_in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(a_in_ready), 32'd0);
    repeat (2) tick();
    check({tag, "_early"}, 32'(a_out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    check({tag, "_bvalid"}, 32'(b_out_valid), 32'd1);
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [1:0] c_exp [8];

  initial begin
    c_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    c_valid = 1'b0; c_data = '0; c_last = 1'b0; c_out_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_total", 32'(a_out_total), 32'd0);
    check("rst_overflow", 32'(a_overflow), 32'd0);
    rst = 1'b0;
    check("rel_ready_lag", 32'(a_in_ready), 32'd0);
    tick();
    check("rel_ready", 32'(a_in_ready), 32'd1);

    // All-ones single-word frame, then a fresh frame
    send_word(8'hFF, 1'b1, "ff");
    check("ff_count", 32'(a_out_count), 32'd8);
    check("ff_total", 32'(a_out_total), 32'd8);
    check("ff_last", 32'(a_out_last), 32'd1);
    release_word();
    check("ff_drop", 32'(a_out_valid), 32'd0);
    send_word(8'h03, 1'b1, "w03");
    check("w03_total", 32'(a_out_total), 32'd2);
    release_word();

    // Three-word frame
    send_word(8'hA5, 1'b0, "a5");
    check("a5_count", 32'(a_out_count), 32'd4);
    check("a5_total", 32'(a_out_total), 32'd4);
    check("a5_last", 32'(a_out_last), 32'd0);
    release_word();
    send_word(8'h0F, 1'b0, "0f");
    check("0f_count", 32'(a_out_count), 32'd4);
    check("0f_total", 32'(a_out_total), 32'd8);
    check("0f_last", 32'(a_out_last), 32'd0);
    release_word();
    send_word(8'h80, 1'b1, "80");
    check("80_count", 32'(a_out_count), 32'd1);
    check("80_total", 32'(a_out_total), 32'd9);
    check("80_last", 32'(a_out_last), 32'd1);
    release_word();

    // Backpressure in OC_DONE with a new word held on the input
    send_word(8'h01, 1'b1, "bp");
    in_valid = 1'b1; in_data = 8'h3C; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(a_out_valid), 32'd1);
      check("bp_hold_count", 32'(a_out_count), 32'd1);
      check("bp_hold_total", 32'(a_out_total), 32'd1);
      check("bp_hold_ready", 32'(a_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_valid", 32'(a_out_valid), 32'd0);
    check("bp_rel_ready", 32'(a_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_accept", 32'(a_in_ready), 32'd0);
    repeat (2) tick();
    check("bp2_early", 32'(a_out_valid), 32'd0);
    tick();
    check("bp2_valid", 32'(a_out_valid), 32'd1);
    check("bp2_count", 32'(a_out_count), 32'd4);
    check("bp2_total", 32'(a_out_total), 32'd4);
    release_word();

    // Narrow accumulator overflow, then reset in the middle of counting
    send_word(8'hFF, 1'b0, "ov1");
    check("ov1_btotal", 32'(b_out_total), 32'd8);
    check("ov1_bovf", 32'(b_overflow), 32'd0);
    release_word();
    send_word(8'hFF, 1'b0, "ov2");
    check("ov2_atotal", 32'(a_out_total), 32'd16);
    check("ov2_aovf", 32'(a_overflow), 32'd0);
`ifdef OC_SATURATE_EN
    check("ov2_btotal", 32'(b_out_total), 32'd15);
`else
    check("ov2_btotal", 32'(b_out_total), 32'd0);
`endif
    check("ov2_bovf", 32'(b_overflow), 32'd1);
    release_word();
    in_valid = 1'b1; in_data = 8'h0F; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(b_out_valid), 32'd0);
    check("mid_rst_bovf", 32'(b_overflow), 32'd0);
    check("mid_rst_ready", 32'(a_in_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rel_ready", 32'(a_in_ready), 32'd1);
    repeat (3) tick();
    check("mid_no_out", 32'(a_out_valid), 32'd0);
    send_word(8'h07, 1'b1, "post");
    check("post_atotal", 32'(a_out_total), 32'd3);
    check("post_btotal", 32'(b_out_total), 32'd3);
    check("post_bovf", 32'(b_overflow), 32'd0);
    release_word();

    // Single-beat build walks every 3-bit input
    for (int v = 0; v < 8; v++) begin
      int waited = 0;
      while (!c_in_ready && waited < 20) begin
        tick();
        waited++;
      end
      check("c_ready", 32'(c_in_ready), 32'd1);
      c_valid = 1'b1; c_data = 3'(v); c_last = 1'b1;
      tick();
      c_valid = 1'b0;
      tick();
      check("c_valid", 32'(c_out_valid), 32'd1);
      check("c_count", 32'(c_out_count), 32'(c_exp[v]));
      check("c_total", 32'(c_out_total), 32'(c_exp[v]));
      c_out_ready = 1'b1;
      tick();
      c_out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
